// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between the LSU or cache-fill logic and mem_access_ctrl.
// BYTE_EN_EN adds the byte write strobe field.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
`ifdef BYTE_EN_EN
  logic [DATA_W/8-1:0] wstrb;
`endif
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
`ifdef BYTE_EN_EN
    output wstrb,
`endif
    output req, we, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
`ifdef BYTE_EN_EN
    input  wstrb,
`endif
    input  req, we, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port data-memory controller: one access per req/ready/done handshake,
// with programmable completion latency. Define BYTE_EN_EN for byte write strobes.
module mem_access_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter int LAT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef BYTE_EN_EN
  localparam int NB = DATA_W / 8;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wait_end;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
`ifdef BYTE_EN_EN
  logic [NB-1:0]     wstrb_p0;
`endif
  logic [DATA_W-1:0] ram_p1;
  logic [DATA_W-1:0] rdata_p2;

  logic              ready;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] mem [DEPTH];

  // Widened compare so DEPTH == 2**ADDR_W works without overflow.
  assign in_range = ({1'b0, addr_p0} < (ADDR_W+1)'(DEPTH));
  assign idx      = addr_p0[IDX_W-1:0];
  assign wait_end = (state == WAIT) && (cnt == CNT_W'(LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
    err   = (state == DONE) && !in_range;
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.err   = err;
  assign bus.rdata = rdata_p2;

  // p0: request capture in IDLE; inputs are free to change afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
`ifdef BYTE_EN_EN
      wstrb_p0 <= '0;
`endif
    end else if (state == IDLE && bus.req) begin
      we_p0    <= bus.we;
      addr_p0  <= bus.addr;
      wdata_p0 <= bus.wdata;
`ifdef BYTE_EN_EN
      wstrb_p0 <= bus.wstrb;
`endif
    end
  end

  // p1: RAM access on the edge leaving ACCESS
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      ram_p1 <= mem[idx];
      if (we_p0 && in_range) begin
`ifdef BYTE_EN_EN
        for (int i = 0; i < NB; i++) begin
          if (wstrb_p0[i]) mem[idx][8*i +: 8] <= wdata_p0[8*i +: 8];
        end
`else
        mem[idx] <= wdata_p0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (state == ACCESS)  cnt <= '0;
    else if (state == WAIT && !wait_end) cnt <= cnt + 1'b1;
    else if (state == DONE)    cnt <= '0;
  end

  // p2: read data lands on the edge entering DONE; writes leave it held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_p2 <= '0;
    end else if (wait_end && !we_p0) begin
      rdata_p2 <= in_range ? ram_p1 : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl (DEPTH=1024, LAT=3); also
// exercises byte strobes when BYTE_EN_EN is defined.
module tb_mem_access_ctrl;
  localparam int DW  = 64;
  localparam int AW  = 11;
  localparam int DEP = 1024;
  localparam int LAT = 3;
  localparam int NB  = DW / 8;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] last_rd;
  logic [AW-1:0] pool [20];

  mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done at cycle %0d: got done=1 expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("err", DW'(bus.err), DW'(e.err));
          chk("rdata", bus.rdata, e.rdata);
          chk("latency", DW'(cyc), DW'(e.cyc));
          chk("ready_with_done", DW'(bus.ready), '0);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_done: got none by cycle %0d expected at %0d", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; waits for ready, drives the request, records the expectation.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] s);
    int   n;
    exp_t e;
    logic [NB-1:0] es;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready=%b expected 1", bus.ready);
      return;
    end
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
`ifdef BYTE_EN_EN
    bus.wstrb = s;
    es = s;
`else
    es = '1;
`endif
    e.err = (int'(a) >= DEP);
    if (int'(a) >= DEP) begin
      if (!w) last_rd = '0;
    end else if (w) begin
      for (int i = 0; i < NB; i++)
        if (es[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    end else begin
      last_rd = mdl[a];
    end
    e.rdata = last_rd;
    e.cyc   = cyc + LAT + 2;
    exp_q.push_back(e);
  endtask

  // Busy window: ready must stay low for LAT+2 cycles; stray requests must be ignored.
  task automatic busy_window();
    logic bad;
    bad = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0) bad = 1'b1;
      bus.req   = 1'($urandom % 2);
      bus.we    = 1'($urandom % 2);
      bus.addr  = AW'($urandom);
      bus.wdata = {$urandom, $urandom};
    end
    chk("ready_low_window", DW'(bad), '0);
    @(negedge clk);
    bus.req = 1'b0;
    chk("ready_return", DW'(bus.ready), DW'(1));
  endtask

  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s);
    issue(w, a, d, s);
    busy_window();
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    last_rd     = '0;
    rst       = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef BYTE_EN_EN
    bus.wstrb = '0;
`endif
    #3;
    chk("reset_ready", DW'(bus.ready), DW'(1));
    chk("reset_done", DW'(bus.done), '0);
    chk("reset_err", DW'(bus.err), '0);
    chk("reset_rdata", bus.rdata, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    pool[0] = 11'h010; pool[1] = 11'd0; pool[2] = 11'd1023; pool[3] = 11'd5;
    for (int i = 4; i < 16; i++) pool[i] = AW'($urandom_range(0, DEP - 1));
    pool[16] = 11'd1024; pool[17] = 11'd2047; pool[18] = 11'd1500; pool[19] = 11'd1025;
    for (int i = 0; i < 16; i++) access(1'b1, pool[i], {$urandom, $urandom}, '1);

    // Write then read back
    access(1'b1, 11'h010, 64'hDEADBEEF_01234567, '1);
    access(1'b0, 11'h010, '0, '0);

    // Range edges
    access(1'b1, 11'd1024, {$urandom, $urandom}, '1);
    access(1'b0, 11'd1023, '0, '0);
    access(1'b0, 11'd1024, '0, '0);
    access(1'b0, 11'd1023, '0, '0);
    access(1'b1, 11'd1023, 64'h0123_4567_89AB_CDEF, '1);
    access(1'b0, 11'd1023, '0, '0);

    // Read data is held across writes
    access(1'b0, 11'd5, '0, '0);
    access(1'b1, 11'h010, {$urandom, $urandom}, '1);
    access(1'b1, 11'd0, {$urandom, $urandom}, '1);
    access(1'b0, 11'd0, '0, '0);

`ifdef BYTE_EN_EN
    access(1'b1, 11'h010, '1, '1);
    access(1'b1, 11'h010, '0, 8'h0F);
    access(1'b0, 11'h010, '0, '0);
    chk("strobe_merge", bus.rdata, 64'hFFFFFFFF_00000000);
    access(1'b1, 11'h010, {$urandom, $urandom}, 8'h00);
    access(1'b0, 11'h010, '0, '0);
`endif

    // Reset in the middle of a read's WAIT phase
    issue(1'b0, 11'h010, '0, '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_ready", DW'(bus.ready), DW'(1));
    chk("midreset_done", DW'(bus.done), '0);
    chk("midreset_err", DW'(bus.err), '0);
    chk("midreset_rdata", bus.rdata, '0);
    exp_q.delete();
    last_rd = '0;
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b1, 11'd5, {$urandom, $urandom}, '1);
    access(1'b0, 11'd5, '0, '0);

    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      a = ($urandom % 10 < 7) ? pool[$urandom_range(0, 15)] : pool[$urandom_range(16, 19)];
      access(1'($urandom % 2), a, {$urandom, $urandom}, NB'($urandom));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
